spi_slave_frontend: RTL and testbench



---
 rtl/spi_slave_frontend_if.sv | 23 ++
 rtl/spi_slave_frontend.sv | 117 +++++++++++
 tb/tb_spi_slave_frontend.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_frontend_if.sv
// Pin/RAM-side bundle of the SPI slave front end; frame_err exists only with SPI_FRAME_ERR_EN.
interface spi_slave_frontend_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;

    modport master (output SS_n, MOSI, tx_data, tx_valid,
                    input  MISO, rx_data, rx_valid, frame_err);
    modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                    output MISO, rx_data, rx_valid, frame_err);
`else
    modport master (output SS_n, MOSI, tx_data, tx_valid,
                    input  MISO, rx_data, rx_valid);
    modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                    output MISO, rx_data, rx_valid);
`endif
endinterface

// File: rtl/spi_slave_frontend.sv
// SPI slave front end: 10-bit MOSI frame -> rx_data/rx_valid (strobe 1 cycle after 10th bit),
// tx_data -> MISO starting the cycle after tx_valid; SS_n high aborts. SPI_FRAME_ERR_EN adds frame_err.
module spi_slave_frontend (
    input logic                 clk,
    input logic                 rst,
    spi_slave_frontend_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [8:0] shift_reg;
    logic       frame_done;
    logic       rd_addr_seen;
    logic [7:0] tx_shift;
    logic [2:0] tx_cnt;
    logic       tx_active;
    logic       tx_sent;
    logic       miso_r;
    logic [9:0] rx_data_r;
    logic       rx_valid_r;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err_r;
    assign bus.frame_err = frame_err_r;
`endif

    assign bus.MISO     = miso_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            shift_reg    <= 9'd0;
            frame_done   <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_shift     <= 8'd0;
            tx_cnt       <= 3'd0;
            tx_active    <= 1'b0;
            tx_sent      <= 1'b0;
            miso_r       <= 1'b0;
            rx_data_r    <= 10'd0;
            rx_valid_r   <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_r  <= 1'b0;
`endif
        end else begin
            rx_valid_r <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_r <= 1'b0;
`endif
            if (bus.SS_n) begin
`ifdef SPI_FRAME_ERR_EN
                // Partial frame, or a completed read whose data never fully left
                frame_err_r <= ((bit_cnt != 4'd0) && !frame_done) ||
                               ((state == READ_DATA) && frame_done && !tx_sent);
`endif
                state      <= IDLE;
                bit_cnt    <= 4'd0;
                shift_reg  <= 9'd0;
                frame_done <= 1'b0;
                tx_shift   <= 8'd0;
                tx_cnt     <= 3'd0;
                tx_active  <= 1'b0;
                tx_sent    <= 1'b0;
                miso_r     <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= CHK_CMD;
                    CHK_CMD: begin
                        shift_reg <= {8'd0, bus.MOSI};
                        bit_cnt   <= 4'd1;
                        if (!bus.MOSI)
                            state <= WRITE;
                        else
                            state <= rd_addr_seen ? READ_DATA : READ_ADD;
                    end
                    default: begin
                        if (!frame_done) begin
                            if (bit_cnt == 4'd9) begin
                                rx_data_r  <= {shift_reg, bus.MOSI};
                                rx_valid_r <= 1'b1;
                                frame_done <= 1'b1;
                                bit_cnt    <= 4'd0;
                                shift_reg  <= 9'd0;
                                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                                if (state == READ_DATA) rd_addr_seen <= 1'b0;
                            end else begin
                                shift_reg <= {shift_reg[7:0], bus.MOSI};
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end else if (state == READ_DATA) begin
                            // tx_cnt holds bits still to send after the one on MISO now
                            if (tx_active) begin
                                if (tx_cnt != 3'd0) begin
                                    miso_r   <= tx_shift[7];
                                    tx_shift <= {tx_shift[6:0], 1'b0};
                                    tx_cnt   <= tx_cnt - 3'd1;
                                end else begin
                                    miso_r    <= 1'b0;
                                    tx_active <= 1'b0;
                                    tx_sent   <= 1'b1;
                                end
                            end else if (!tx_sent && bus.tx_valid) begin
                                miso_r    <= bus.tx_data[7];
                                tx_shift  <= {bus.tx_data[6:0], 1'b0};
                                tx_cnt    <= 3'd7;
                                tx_active <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_frontend.sv
module tb_spi_slave_frontend;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_frontend_if bus ();
    spi_slave_frontend dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_rx_q[$];
    logic       exp_miso_q[$];
    logic       exp_ferr = 1'b0;

    // Advance one cycle, then pop the scoreboard against what the DUT produced.
    task automatic tick(input string tag);
        logic em;
        logic [9:0] er;
        @(posedge clk);
        #1;
        em = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 1'b0;
        n_vec++;
        if (bus.MISO !== em) begin
            n_err++;
            $display("FAIL %s miso got=%b want=%b", tag, bus.MISO, em);
        end
        if (bus.rx_valid === 1'b1) begin
            n_vec++;
            if (exp_rx_q.size() == 0) begin
                n_err++;
                $display("FAIL %s unexpected rx_valid rx_data=%h", tag, bus.rx_data);
            end else begin
                er = exp_rx_q.pop_front();
                if (bus.rx_data !== er) begin
                    n_err++;
                    $display("FAIL %s rx_data got=%h want=%h", tag, bus.rx_data, er);
                end
            end
        end else if (bus.rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s rx_valid got=%b want=0/1", tag, bus.rx_valid);
        end
`ifdef SPI_FRAME_ERR_EN
        n_vec++;
        if (bus.frame_err !== exp_ferr) begin
            n_err++;
            $display("FAIL %s frame_err got=%b want=%b", tag, bus.frame_err, exp_ferr);
        end
        exp_ferr = 1'b0;
`endif
    endtask

    task automatic send_frame(input logic [9:0] f, input string tag);
        bus.SS_n = 1'b0;
        tick(tag);
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = f[i];
            if (i == 0) exp_rx_q.push_back(f);
            tick(tag);
        end
        bus.MOSI = 1'b0;
    endtask

    task automatic end_frame(input string tag);
        bus.SS_n = 1'b1;
        exp_miso_q.delete();
        tick(tag);
    endtask

    task automatic push_tx(input logic [7:0] d);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        for (int i = 7; i >= 0; i--) exp_miso_q.push_back(d[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'd0;
        #12;
        n_vec++;
        if (bus.MISO !== 1'b0 || bus.rx_valid !== 1'b0 || bus.rx_data !== 10'd0) begin
            n_err++;
            $display("FAIL reset outputs miso=%b rx_valid=%b rx_data=%h want 0/0/000",
                     bus.MISO, bus.rx_valid, bus.rx_data);
        end
        n_vec++;
        if (dut.rd_addr_seen !== 1'b0) begin
            n_err++;
            $display("FAIL reset rd_addr_seen got=%b want=0", dut.rd_addr_seen);
        end
`ifdef SPI_FRAME_ERR_EN
        n_vec++;
        if (bus.frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset frame_err got=%b want=0", bus.frame_err);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        tick("reset_idle");
    endtask

    task automatic test_write(input logic [9:0] f, input string tag);
        send_frame(f, tag);
        for (int i = 0; i < 3; i++) begin
            bus.MOSI = 1'($urandom_range(0, 1));
            tick({tag, "_trail"});
        end
        end_frame(tag);
        n_vec++;
        if (exp_rx_q.size() != 0) begin
            n_err++;
            $display("FAIL %s rx pending got=%0d want=0", tag, exp_rx_q.size());
        end
    endtask

    task automatic test_read();
        send_frame(10'h207, "read_addr");
        end_frame("read_addr");
        n_vec++;
        if (dut.rd_addr_seen !== 1'b1) begin
            n_err++;
            $display("FAIL read_addr rd_addr_seen got=%b want=1", dut.rd_addr_seen);
        end
        send_frame(10'h35A, "read_data");
        tick("read_wait");
        tick("read_wait");
        push_tx(8'hC3);
        tick("read_miso");
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        for (int i = 0; i < 8; i++) tick("read_miso");
        n_vec++;
        if (dut.rd_addr_seen !== 1'b0 || exp_rx_q.size() != 0) begin
            n_err++;
            $display("FAIL read_data rd_addr_seen=%b pending=%0d want 0/0",
                     dut.rd_addr_seen, exp_rx_q.size());
        end
        end_frame("read_data");
    endtask

    task automatic test_partial();
        logic [9:0] f;
        f = 10'h3FF;
        bus.SS_n = 1'b0;
        tick("partial");
        for (int i = 9; i >= 4; i--) begin
            bus.MOSI = f[i];
            tick("partial");
        end
        exp_ferr = 1'b1;
        end_frame("partial_end");
        test_write(10'h155, "after_partial");
    endtask

    task automatic test_stray_tx();
        push_tx(8'hFF);
        exp_miso_q.delete();
        test_write(10'h0FF, "stray_tx");
        tick("stray_tx_idle");
        bus.tx_valid = 1'b0;
    endtask

    task automatic test_abort();
        send_frame(10'h2AA, "abort_addr");
        end_frame("abort_addr");
        send_frame(10'h3F0, "abort_data");
        push_tx(8'hA5);
        tick("abort_miso");
        bus.tx_valid = 1'b0;
        tick("abort_miso");
        tick("abort_miso");
        exp_ferr = 1'b1;
        end_frame("abort_end");
        n_vec++;
        if (dut.rd_addr_seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort rd_addr_seen got=%b want=0", dut.rd_addr_seen);
        end
    endtask

    task automatic test_async_reset();
        send_frame(10'h205, "arst_addr");
        end_frame("arst_addr");
        send_frame(10'h3AB, "arst_data");
        push_tx(8'h96);
        tick("arst_miso");
        bus.tx_valid = 1'b0;
        tick("arst_miso");
        tick("arst_miso");
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.MISO !== 1'b0 || bus.rx_valid !== 1'b0 || dut.rd_addr_seen !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset miso=%b rx_valid=%b rd_addr_seen=%b want 0/0/0",
                     bus.MISO, bus.rx_valid, dut.rd_addr_seen);
        end
        exp_miso_q.delete();
        bus.SS_n = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        // First 11-frame after reset must act as READ_ADD: no read data shifted out
        send_frame(10'h3CC, "post_rst_addr");
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'hFF;
        tick("post_rst_addr_tx");
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick("post_rst_addr_tx");
        n_vec++;
        if (dut.rd_addr_seen !== 1'b1) begin
            n_err++;
            $display("FAIL post_rst rd_addr_seen got=%b want=1", dut.rd_addr_seen);
        end
        end_frame("post_rst_addr");
        send_frame(10'h300, "post_rst_data");
        push_tx(8'h5A);
        tick("post_rst_miso");
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick("post_rst_miso");
        end_frame("post_rst_data");
        n_vec++;
        if (exp_rx_q.size() != 0) begin
            n_err++;
            $display("FAIL post_rst rx pending got=%0d want=0", exp_rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write(10'h0A5, "write_addr");
        test_write(10'h13C, "write_data");
        test_read();
        test_partial();
        test_stray_tx();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
